// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential array multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to index every multiplier bit; never less than one.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/pp_row_adder.sv
// One partial-product row: gates the multiplicand with the current
// multiplier bit and adds (or subtracts) it to the upper accumulator slice
// through a WIDTH+1-bit ripple chain.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module pp_row_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] acc_hi_i,  // upper accumulator slice, extended by one bit
  input  logic [WIDTH:0] row_i,     // multiplicand, extended by one bit
  input  logic           row_en_i,  // current multiplier bit
  input  logic           sub_i,     // subtract the row instead of adding it
  output logic [WIDTH:0] sum_o
);

  logic [WIDTH:0] gated;
  logic [WIDTH:0] operand;
  logic [WIDTH:0] carry;

  // Subtraction is two's complement: invert the gated row and inject a carry.
  always_comb begin
    gated   = row_en_i ? row_i : '0;
    operand = sub_i ? ~gated : gated;
  end

  assign carry[0] = sub_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a_i (acc_hi_i[i]),
      .b_i (operand[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end

  // The top cell's carry-out can never be significant, so only its sum is formed.
  assign sum_o[WIDTH] = acc_hi_i[WIDTH] ^ operand[WIDTH] ^ carry[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add multiplier: one partial-product row per clock,
// valid/ready on both sides, fixed latency of WIDTH cycles.
// Define MULT_SIGNED_EN for a two's-complement build (last row subtracts).
// The accumulator shifts right one bit per row so that a single WIDTH+1-bit
// row adder always works on the upper slice; after WIDTH rows it holds a*b.

module seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z
);

  localparam int CW = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic                 last_row;
  logic                 acc_ext;
  logic                 row_ext;
  logic                 row_sub;
  logic [WIDTH:0]       row_sum;
  logic [2*WIDTH-1:0]   acc_shift;

  assign last_row = (cnt_q == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
  assign acc_ext = acc_q[2*WIDTH-1];
  assign row_ext = mcand_q[WIDTH-1];
  assign row_sub = last_row;
`else
  assign acc_ext = 1'b0;
  assign row_ext = 1'b0;
  assign row_sub = 1'b0;
`endif

  pp_row_adder #(.WIDTH(WIDTH)) u_row (
    .acc_hi_i ({acc_ext, acc_q[2*WIDTH-1:WIDTH]}),
    .row_i    ({row_ext, mcand_q}),
    .row_en_i (mplier_q[cnt_q]),
    .sub_i    (row_sub),
    .sum_o    (row_sum)
  );

  assign acc_shift = {row_sum, acc_q[WIDTH-1:1]};

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;

  // Next-state, datapath updates and operand capture.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    z_d      = z_q;

    case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_row) begin
          z_d     = acc_shift;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepting overrides the DONE->IDLE hand-off so both happen on one edge.
    if (in_valid && in_ready) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = BUSY;
    end
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  // Operand registers; loaded on every accept before they are read.
  always_ff @(posedge clk) begin
    // NOTE: no reset here, since the FSM never reads these outside BUSY.
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Scoreboard bench for seq_array_multiplier: the driver pushes the expected
// product (from plain arithmetic) when an accept happens; an independent
// monitor compares every presented result, its latency and the handshakes.
module tb_seq_array_multiplier;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   z;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_cycle;
  } exp_t;

  exp_t           sb_q[$];
  int             checks   = 0;
  int             failures = 0;
  int             cycle    = 0;
  logic [2*W-1:0] last_z   = '0;
  bit             seen_flag = 1'b0;
  bit             late_flag = 1'b0;
  bit             rand_ready = 1'b0;

  seq_array_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference product straight from the arithmetic definition.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_SIGNED_EN
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint p  = sx * sy;
`else
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint unsigned p  = ux * uy;
`endif
    return p[2*W-1:0];
  endfunction

  // Edge counter: at a negedge, cycle equals the index of the last rising edge.
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Randomised downstream backpressure while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: checks handshakes and results at the falling edge.
  initial begin
    logic exp_ready;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_ready = out_valid ? out_ready : (sb_q.size() == 0);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            check("z", 64'(z), 64'(sb_q[0].prod));
            if (!seen_flag) begin
              check("latency", 64'(cycle), 64'(sb_q[0].acc_cycle + W));
              seen_flag = 1'b1;
            end
            if (out_ready) begin
              last_z = sb_q[0].prod;
              void'(sb_q.pop_front());
              seen_flag = 1'b0;
              late_flag = 1'b0;
            end
          end
        end else begin
          check("z_hold", 64'(z), 64'(last_z));
          if (sb_q.size() != 0 && !late_flag && cycle > sb_q[0].acc_cycle + W) begin
            check("late_out_valid", 64'(out_valid), 64'd1);
            late_flag = 1'b1;
          end
        end
      end
    end
  end

  // Present operands until accepted; the expected product is queued on the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    int  waited = 0;
    bit  took   = 1'b0;
    exp_t e;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        e.prod      = ref_mul(av, bv);
        e.acc_cycle = cycle;
        sb_q.push_back(e);
      end else if (++waited > 200) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    if (n >= 50) check("wait_valid_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  // One-cycle synchronous reset; discards anything in flight.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    last_z    = '0;
    seen_flag = 1'b0;
    late_flag = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Corners: all-ones and a zero operand (full latency still applies).
    out_ready = 1'b1;
    send(8'd255, 8'd255);
    wait_idle();
    send(8'd0, 8'd200);
    wait_idle();

    // Backpressure: result held while out_ready is low; stray in_valid ignored.
    out_ready = 1'b0;
    send(8'd12, 8'd13);
    a = 8'hAA;
    b = 8'h55;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'(i + 33);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back: hand-off and accept share an edge.
    send(8'd7, 8'd9);
    send(8'd100, 8'd3);
    wait_idle();

    // Reset on the fourth BUSY edge, then a fresh product.
    send(8'd50, 8'd60);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send(8'd5, 8'd6);
    wait_idle();

    // Reset while a result is stalled in DONE.
    out_ready = 1'b0;
    send(8'd9, 8'd9);
    wait_valid();
    do_reset();
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Sign-sensitive vectors (interpreted per build by the reference).
    send(8'hFD, 8'd5);
    send(8'h80, 8'hFF);
    send(8'h80, 8'h80);
    send(8'h7F, 8'h80);
    wait_idle();

    // Random operands, random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ((i % 7) == 0) ra = '1;
      if ((i % 11) == 3) rb = {1'b1, {(W-1){1'b0}}};
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(ra, rb);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_array_multiplier.md
# seq_array_multiplier

Parametrised, sequential successor to the combinational 2x2 array multiplier. Multiplies two WIDTH-bit operands by accumulating one partial-product row per clock through a WIDTH-bit full-adder row. It produces the exact 2*WIDTH-bit product with a fixed latency. It sits in the arithmetic datapath behind valid/ready handshakes on both input and output, so upstream and downstream may stall it freely.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b valid this cycle
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  z holds a completed product
- out_ready  input  1  downstream consumes z this cycle
- z  output  2*WIDTH  product a*b

## Operation
- States:
  - IDLE: waiting for operands.
  - BUSY: accumulating rows.
  - DONE: result presented.
- Counter cnt: $clog2(WIDTH) bits, indexes the current multiplier bit.
- Accept: in_valid && in_ready at a rising edge.
  - Registers a into mcand and b into mplier.
  - Clears the 2*WIDTH-bit accumulator acc.
  - Sets cnt=0 and moves to BUSY.
- BUSY, each edge:
  - If mplier[cnt]=1, add mcand<<cnt into acc; otherwise acc is unchanged.
  - Then cnt++.
  - On the edge where cnt==WIDTH-1, acc is copied to z and the state moves to DONE.
- DONE:
  - out_valid=1; z is held stable until handshake.
  - On out_valid && out_ready: go to IDLE, or accept new operands directly if in_valid is high that cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only, never from in_valid.
- Operands are unsigned by default.
- z is always the exact product; no truncation or overflow is possible in 2*WIDTH bits.
- z holds the last product after the handshake until the next result overwrites it.
- Operand a or b equal to 0 still takes the full latency; there is no early termination.
- Reset values: state=IDLE, cnt=0, acc=0, z=0, out_valid=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation, in BUSY or DONE: the in-flight result is discarded, out_valid drops to 0 on that edge, and no partial z is emitted.

## Timing
- Latency: out_valid is high exactly WIDTH cycles after the accepting edge. The accept edge is E0; out_valid is high after edge E_WIDTH.
- Throughput without stall is one product per WIDTH+1 cycles: accept and hand-off overlap in DONE.
- in_valid during BUSY is ignored; in_ready=0 there.
- Backpressure: while out_ready=0 in DONE, z and out_valid are held with no change.
- Simultaneous out_ready=1 and in_valid=1 in DONE: result hand-off and new accept occur on the same edge. The next state is BUSY, and out_valid falls.

## Configuration
- MULT_SIGNED_EN, when defined:
  - a, b and z are two's complement.
  - Rows 0..WIDTH-2 add the sign-extended mcand<<cnt.
  - Row WIDTH-1 (the multiplier sign bit) subtracts the sign-extended mcand<<(WIDTH-1).
  - Result: z = $signed(a)*$signed(b), exact in 2*WIDTH bits, including -2^(WIDTH-1) * -2^(WIDTH-1).
- When undefined: the unsigned behaviour described above. Port list and latency are identical in both builds.

## Structure
- Package mult_pkg:
  - State enum (IDLE, BUSY, DONE).
  - Default WIDTH constant.
  - Function giving the counter width from WIDTH.
- Sub-module pp_row_adder:
  - A WIDTH+1-bit ripple row built from full_adder cells.
  - Adds the gated multiplicand row to the upper accumulator slice.
  - Has a sub input: invert the row and set carry-in=1. This is used only under MULT_SIGNED_EN on the last row.
- Top level holds the FSM, counter, operand and accumulator registers, and output register.

## Test plan
- WIDTH=2, unsigned build, a=3, b=2 -> z=6, out_valid rises 2 cycles after accept, in_ready=0 during BUSY.
- WIDTH=8, unsigned build: a=255, b=255 -> z=65025 (0xFE01) after 8 cycles; a=0, b=200 -> z=0, same latency.
- WIDTH=8, unsigned build: hold out_ready=0 for 5 cycles in DONE with a=12, b=13 -> z=156 stable and out_valid=1 throughout; in_valid pulses ignored.
- WIDTH=8, back-to-back: in_valid and out_ready held high with pairs (7,9), (100,3) -> z=63 then z=300, second result exactly 9 cycles after the first.
- WIDTH=8: assert rst during cycle 4 of BUSY -> out_valid=0, z=0, in_ready=1 next cycle; next operands 5*6 -> z=30.
- WIDTH=8, MULT_SIGNED_EN:
  - -3*5 -> z=0xFFF1.
  - -128*-1 -> z=0x0080.
  - -128*-128 -> z=0x4000.
  - 127*-128 -> z=0xC080.
